// File: rtl/vector_pkg.sv
// Shared constants and types for the vector execute stage.
package vector_pkg;
  localparam int N      = 64;
  localparam int LANE   = 8;
  localparam int NLANES = N / LANE;

  typedef logic [NLANES-1:0][LANE-1:0] vec_t;

  typedef enum logic [2:0] {
    VADD = 3'b000,
    VSUB = 3'b001,
    VXOR = 3'b010,
    VAND = 3'b011,
    VOR  = 3'b100,
    VMUL = 3'b101,
    VSHL = 3'b110,
    VMOV = 3'b111
  } vop_t;

  typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/vector_mul_step.sv
// One shift-add multiply iteration applied to every lane in parallel.
module vector_mul_step
  import vector_pkg::*;
(
  input  vec_t       acc,
  input  vec_t       a,
  input  vec_t       b,
  input  logic [2:0] cnt,
  output vec_t       nxt
);
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    // Lane-local shift truncates to 8 bits, so partial products never leak across lanes.
    assign nxt[i] = acc[i] + (b[i][cnt] ? (a[i] << cnt) : '0);
  end
endmodule

// File: rtl/vector_exec_unit.sv
// Registered lane-wise vector execute stage: single-cycle ALU ops plus 8-cycle lane multiply.
module vector_exec_unit
  import vector_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] C
);
  state_t     state;
  logic [2:0] cnt;
  vec_t       acc, mul_a, mul_b, acc_nxt, va, vb, alu;

  assign va = A;
  assign vb = B;

  always_comb begin
    alu = '0;
    for (int i = 0; i < NLANES; i++) begin
      case (vop_t'(op))
        VADD:    alu[i] = va[i] + vb[i];
        VSUB:    alu[i] = va[i] - vb[i];
        VXOR:    alu[i] = va[i] ^ vb[i];
        VAND:    alu[i] = va[i] & vb[i];
        VOR:     alu[i] = va[i] | vb[i];
        VSHL:    alu[i] = va[i] << vb[i][2:0];
        VMOV:    alu[i] = va[i];
        default: alu[i] = '0;
      endcase
    end
  end

  vector_mul_step u_step (
    .acc (acc),
    .a   (mul_a),
    .b   (mul_b),
    .cnt (cnt),
    .nxt (acc_nxt)
  );

  // A pending result blocks acceptance unless it is being delivered this edge.
  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      C         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            if (vop_t'(op) == VMUL) begin
              mul_a <= A;
              mul_b <= B;
              acc   <= '0;
              cnt   <= '0;
              state <= MUL;
            end else begin
              C         <= alu;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            C         <= acc_nxt;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_exec_unit.sv
// Randomized and directed bench for vector_exec_unit against a transaction-level model.
module tb_vector_exec_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [2:0]  op = 0;
  logic [63:0] A = 0, B = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [63:0] C;

  int checks = 0;
  int errors = 0;

  // Model: pending result, cycles left on a running multiply, its result.
  bit          m_valid;
  logic [63:0] m_c;
  int          m_busy;
  logic [63:0] m_res;

  always #5 clk = ~clk;

  vector_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    int x, y, z;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      x = int'(a[l*8 +: 8]);
      y = int'(b[l*8 +: 8]);
      case (o)
        3'd0: z = x + y;
        3'd1: z = x - y + 256;
        3'd2: z = x ^ y;
        3'd3: z = x & y;
        3'd4: z = x | y;
        3'd5: z = x * y;
        3'd6: z = x * (1 << (y % 8));
        default: z = x;
      endcase
      r[l*8 +: 8] = 8'(z % 256);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_c     = '0;
    m_busy  = 0;
    m_res   = '0;
  endtask

  task automatic check_outputs(input string tag);
    bit m_ready;
    m_ready = (m_busy == 0) && (!m_valid || out_ready);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(m_ready));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, "_c"}, C, m_c);
  endtask

  // Called at a negedge: drive inputs, advance model over the next posedge, check at following negedge.
  task automatic step(input logic iv, input logic [2:0] o, input logic [63:0] a,
                      input logic [63:0] b, input logic ordy, input string tag);
    bit ready, acc, dlv;
    in_valid  = iv;
    op        = o;
    A         = a;
    B         = b;
    out_ready = ordy;
    ready = (m_busy == 0) && (!m_valid || ordy);
    acc   = iv && ready;
    dlv   = m_valid && ordy;
    #1 chk({tag, "_pre_in_ready"}, 64'(in_ready), 64'(ready));
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1;
        m_c     = m_res;
      end
    end else begin
      if (dlv) m_valid = 0;
      if (acc) begin
        if (o == 3'd5) begin
          m_busy = 8;
          m_res  = ref_op(o, a, b);
        end else begin
          m_valid = 1;
          m_c     = ref_op(o, a, b);
        end
      end
    end
    @(negedge clk);
    #1 check_outputs(tag);
  endtask

  initial begin
    model_reset();
    #2 chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_c", C, 64'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk("rel_in_ready", 64'(in_ready), 64'd1);

    // ADD lane 0 wrap, no carry into lane 1
    step(1, 3'd0, 64'h0000_0000_0000_01FF, 64'h0000_0000_0000_0101, 1, "add");
    chk("add_vec", C, 64'h0000_0000_0000_0200);
    step(1, 3'd1, 64'h0, 64'h0101_0101_0101_0101, 1, "sub");
    chk("sub_vec", C, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1, 3'd2, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1, "xor");
    chk("xor_vec", C, 64'h0);

    // MUL: 8 busy cycles then result
    step(1, 3'd5, 64'h0202_0202_03FF_100F, 64'h0707_0707_05FF_1011, 1, "mul_acc");
    for (int i = 0; i < 7; i++) step(1, 3'd0, 64'h1, 64'h1, 1, "mul_busy");
    chk("mul_not_yet", 64'(out_valid), 64'd0);
    step(0, 3'd0, 64'h0, 64'h0, 0, "mul_done");
    chk("mul_vec", C, 64'h0E0E_0E0E_0F01_00FF);

    // Backpressure: result held 5 cycles, pending in_valid then accepted on deliver edge
    for (int i = 0; i < 5; i++) step(1, 3'd6, 64'h8181_8181_8181_8181, 64'h0101_0101_0101_0101, 0, "stall");
    chk("stall_hold", C, 64'h0E0E_0E0E_0F01_00FF);
    step(1, 3'd6, 64'h8181_8181_8181_8181, 64'h0101_0101_0101_0101, 1, "shl");
    chk("shl_vec", C, 64'h0202_0202_0202_0202);
    step(1, 3'd0, 64'h0102_0304_0506_0708, 64'h1111_1111_1111_1111, 1, "b2b_add");
    step(1, 3'd1, 64'h0102_0304_0506_0708, 64'h1111_1111_1111_1111, 1, "b2b_sub");
    step(1, 3'd6, 64'h8181_8181_8181_8181, 64'h0101_0101_0101_0101, 1, "b2b_shl");
    chk("b2b_valid", 64'(out_valid), 64'd1);

    // Reset in the 4th MUL cycle
    step(1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0303_0303_0303_0303, 1, "mr_acc");
    for (int i = 0; i < 3; i++) step(0, 3'd0, 64'h0, 64'h0, 1, "mr_busy");
    rst = 1;
    model_reset();
    #1 chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_c", C, 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 0;
    #1 chk("mr_rel_ready", 64'(in_ready), 64'd1);
    step(1, 3'd7, 64'h0123_4567_89AB_CDEF, 64'h0, 1, "mov");
    chk("mov_vec", C, 64'h0123_4567_89AB_CDEF);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0), "rnd");
    end
    for (int i = 0; i < 12; i++) step(0, 3'd0, 64'h0, 64'h0, 1, "drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
